ka_mod_shift_restore: RTL
=========================

// Module: ka_mod_shift_restore
// PURPOSE
//   Montgomery-domain entry: computes R = A * 2^(W*L) mod q, the inverse of the
//   2^-(W*L) factor applied by the cascaded word-level ModRed stages.
//   Bit-serial modular doubling, one doubling per cycle (two with the optional
//   feature), with valid/ready handshakes on input and output.
//   Sits ahead of the NTT datapath to pre-scale twiddles/operands; one operation
//   in flight at a time.
// PARAMETERS
//   DATA_W  32  operand width (A, q, R); q < 2^(DATA_W-1)
//   W       16  reduction word size per ModRed stage
//   L       2   number of ModRed stages to compensate; SHIFT = W*L doublings
// PORTS
//   clk        in   1       clock
//   reset      in   1       asynchronous, active-high reset
//   in_valid   in   1       A/q present
//   in_ready   out  1       block can accept an operand (IDLE only)
//   a          in   DATA_W  operand A, must satisfy A < 2q
//   q          in   DATA_W  modulus, odd, q >= 3
//   out_valid  out  1       R valid
//   out_ready  in   1       consumer accepts R
//   r          out  DATA_W  result R, always in [0, q-1]
//   busy       out  1       high in RUN or DONE
// BEHAVIOUR
//   Reset: state=IDLE, r=0, out_valid=0, busy=0, in_ready=1, internal counter=0,
//     latched q=0; async reset mid-RUN/DONE aborts the operation, result discarded.
//   States:
//   - IDLE: in_ready=1. On in_valid&&in_ready at edge k: latch q; acc = (a>=q) ? a-q : a.
//     Counter=SHIFT. Go to RUN.
//   - RUN: in_ready=0. Each cycle: t = {acc,1'b0} (DATA_W+1 bits);
//     acc = (t>=q) ? t-q : t. Counter decrements by 1.
//     On the edge where counter goes 1->0: go to DONE.
//   - DONE: out_valid=1, r=acc held stable while out_ready=0.
//     On out_valid&&out_ready: out_valid=0, go to IDLE.
//   Latency: out_valid rises after edge k+SHIFT (SHIFT RUN cycles); no overlap.
//     Next input is accepted at the earliest one cycle after the output handshake.
//   in_valid is ignored outside IDLE; a/q changes after capture have no effect.
//   Arithmetic: all compares/subtracts on DATA_W+1 bits; acc < q holds after every step.
//     A >= 2q or even q: result unspecified (caller contract, not checked).
//   r is driven from the internal accumulator only in DONE; it holds the last
//     result in IDLE until the next DONE.
// CONFIGURATION
//   MODSHIFT_DUAL_STEP_EN defined: RUN applies two chained doublings per cycle.
//     Counter starts at SHIFT/2; latency SHIFT/2 cycles. SHIFT must be even;
//     elaboration error otherwise. Result is identical to the single-step build.
//   Undefined: one doubling per cycle, latency SHIFT (default).
// TESTING  (DATA_W=32, W=16, L=2, SHIFT=32, q=12289 unless noted)
//   a=1 -> r=10952 (2^32 mod 12289); out_valid 32 cycles after capture edge.
//   a=12288 (q-1) -> r=1337; a=0 -> r=0; a=12289 (=q, preload path) -> r=0.
//   Hold out_ready=0 for 5 cycles in DONE -> r, out_valid stable; in_ready=0;
//     in_valid pulses are ignored.
//   Assert reset at RUN cycle 10 -> out_valid=0, r=0, busy=0.
//     Fresh a=1 after release -> r=10952.
//   Back-to-back stream of 100 random a<q, random out_ready stalls ->
//     every r matches a*2^32 mod q in order.
//   With MODSHIFT_DUAL_STEP_EN: a=1 -> r=10952 with 16-cycle latency.

Source files
------------

// File: rtl/ka_mod_shift_restore.sv
// Montgomery-domain entry: R = A * 2^(W*L) mod q by bit-serial modular doubling.
// Optional MODSHIFT_DUAL_STEP_EN: two chained doublings per RUN cycle.
module ka_mod_shift_restore #(
    parameter int DATA_W = 32,
    parameter int W      = 16,
    parameter int L      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] r,
    output logic              busy
);

    localparam int SHIFT = W * L;
`ifdef MODSHIFT_DUAL_STEP_EN
    localparam int STEPS = SHIFT / 2;
    if (SHIFT % 2 != 0) begin : g_shift_even_check
        $error("ka_mod_shift_restore: W*L must be even for the dual-step build");
    end
`else
    localparam int STEPS = SHIFT;
`endif
    localparam int CNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   q_reg;
    logic [DATA_W-1:0]   r_reg;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   preload;
    logic [DATA_W-1:0]   step_acc;
    logic                last_step;

    // One modular doubling; the extra top bit keeps 2*x exact before the subtract.
    function automatic logic [DATA_W-1:0] mod_double(input logic [DATA_W-1:0] x,
                                                     input logic [DATA_W-1:0] m);
        logic [DATA_W:0] t;
        t = {x, 1'b0};
        if (t >= {1'b0, m})
            t = t - {1'b0, m};
        return t[DATA_W-1:0];
    endfunction

    always_comb begin
        preload = (a >= q) ? (a - q) : a;
`ifdef MODSHIFT_DUAL_STEP_EN
        step_acc = mod_double(mod_double(acc, q_reg), q_reg);
`else
        step_acc = mod_double(acc, q_reg);
`endif
        last_step = (cnt == CNT_W'(1));
    end

    // NOTE: every register is in the async-reset domain and updated with <=;
    // blocking assignments here would create ordering races between processes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: all outputs get a default before the case so no path infers a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid)
                    state_next = RUN;
            end
            RUN: begin
                if (last_step)
                    state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            q_reg <= '0;
            r_reg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_reg <= q;
                        acc   <= preload;
                        cnt   <= CNT_W'(STEPS);
                    end
                end
                RUN: begin
                    acc <= step_acc;
                    cnt <= cnt - CNT_W'(1);
                    // r only moves on entry to DONE and then holds through IDLE.
                    if (last_step)
                        r_reg <= step_acc;
                end
                default: ;
            endcase
        end
    end

    assign r = r_reg;

endmodule
